// File: rtl/leading_one_decoder.sv
// Iterative leading-one index decoder: rebuilds a one-hot word or a thermometer
// mask from a leading-one index by shifting a single one upward once per cycle.
module leading_one_decoder #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    input  logic             in_therm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             therm_q, therm_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            therm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            err_q   <= err_d;
            therm_q <= therm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        err_d   = err_q;
        therm_d = therm_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    therm_d = in_therm;
                    err_d   = 1'b0;
                    if (in_index == '0) begin
                        data_d  = '0;
                        state_d = DONE;
                    end else if (in_index > IDX_W'(WIDTH)) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        data_d = {{(WIDTH-1){1'b0}}, 1'b1};
                        if (in_index == IDX_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            // k-1 shifts remain to move the seed bit to position k-1
                            count_d = in_index - IDX_W'(1);
                            state_d = SHIFT;
                        end
                    end
                end
            end
            SHIFT: begin
                data_d  = {data_q[WIDTH-2:0], therm_q};
                count_d = count_q - IDX_W'(1);
                if (count_q == IDX_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_leading_one_decoder.sv
// Table-driven bench for leading_one_decoder with directed backpressure,
// mid-operation reset and randomly stalled round-trip sequences.
module tb_leading_one_decoder;

    localparam int unsigned WIDTH = 9;
    localparam int unsigned IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_index;
    logic             in_therm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             busy;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    leading_one_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_index (in_index),
        .in_therm (in_therm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] k;
        logic             therm;
        logic [WIDTH-1:0] exp_data;
        logic             exp_err;
        int unsigned      exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int unsigned lo_enc(input logic [WIDTH-1:0] d);
        int unsigned r = 0;
        for (int i = 0; i < int'(WIDTH); i++) if (d[i]) r = i + 1;
        return r;
    endfunction

    // Issue one request and wait for the result; returns observed latency and data.
    // Inputs are driven and outputs sampled on the falling edge.
    task automatic issue(input logic [IDX_W-1:0] k, input logic t, input bit rand_ready,
                         output int unsigned lat);
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_index  = k;
        in_therm  = t;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_index = 4'hA;
        lat = 1;
        while (!out_valid && lat < 20) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
    endtask

    // Hold the result for `stall` cycles, then complete the output handshake.
    task automatic drain(input int unsigned stall, input logic [WIDTH-1:0] d, input bit poke);
        for (int i = 0; i < int'(stall); i++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_index = 4'(i + 1);
            end
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {23'd0, out_data}, {23'd0, d});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_handshake", {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int unsigned lat;
        int unsigned seen;

        for (int k = 0; k <= 9; k++)
            vecs.push_back('{4'(k), 1'b0, (k == 0) ? 9'h000 : 9'(1 << (k - 1)), 1'b0,
                            (k == 0) ? 1 : k});
        vecs.push_back('{4'd1, 1'b1, 9'h001, 1'b0, 1});
        vecs.push_back('{4'd2, 1'b1, 9'h003, 1'b0, 2});
        vecs.push_back('{4'd3, 1'b1, 9'h007, 1'b0, 3});
        vecs.push_back('{4'd4, 1'b1, 9'h00F, 1'b0, 4});
        vecs.push_back('{4'd5, 1'b1, 9'h01F, 1'b0, 5});
        vecs.push_back('{4'd6, 1'b1, 9'h03F, 1'b0, 6});
        vecs.push_back('{4'd7, 1'b1, 9'h07F, 1'b0, 7});
        vecs.push_back('{4'd8, 1'b1, 9'h0FF, 1'b0, 8});
        vecs.push_back('{4'd9, 1'b1, 9'h1FF, 1'b0, 9});
        vecs.push_back('{4'd10, 1'b0, 9'h000, 1'b1, 1});
        vecs.push_back('{4'd15, 1'b0, 9'h000, 1'b1, 1});
        vecs.push_back('{4'd10, 1'b1, 9'h000, 1'b1, 1});
        vecs.push_back('{4'd15, 1'b1, 9'h000, 1'b1, 1});

        rst_n = 1'b0; in_valid = 1'b0; in_index = '0; in_therm = 1'b0; out_ready = 1'b0;
        #12;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_data", {23'd0, out_data}, 32'd0);
        chk("reset_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].k, vecs[i].therm, 1'b0, lat);
            chk($sformatf("lat_k%0d_t%0d", vecs[i].k, vecs[i].therm), lat, vecs[i].exp_lat);
            chk($sformatf("data_k%0d_t%0d", vecs[i].k, vecs[i].therm),
                {23'd0, out_data}, {23'd0, vecs[i].exp_data});
            chk($sformatf("err_k%0d_t%0d", vecs[i].k, vecs[i].therm),
                {31'd0, out_err}, {31'd0, vecs[i].exp_err});
            drain(0, vecs[i].exp_data, 1'b0);
        end

        // Backpressure with new indices offered while the result is held
        issue(4'd4, 1'b0, 1'b0, lat);
        chk("bp_lat", lat, 4);
        chk("bp_data", {23'd0, out_data}, 32'h008);
        drain(6, 9'h008, 1'b1);
        issue(4'd3, 1'b1, 1'b0, lat);
        chk("bp_next_lat", lat, 3);
        chk("bp_next_data", {23'd0, out_data}, 32'h007);
        drain(0, 9'h007, 1'b0);

        // Reset dropped in cycle 4 of a k=9 request
        @(negedge clk);
        in_valid = 1'b1; in_index = 4'd9; in_therm = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_data", {23'd0, out_data}, 32'h008);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", {23'd0, out_data}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("mid_rst_no_result", seen, 0);

        // Round trip through the leading-one encoder with random stalls
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) begin
                issue(4'(k), 1'(m), 1'b1, lat);
                chk($sformatf("rt_lat_k%0d_t%0d", k, m), lat, (k == 0 || k > 9) ? 1 : k);
                if (k <= 9) begin
                    chk($sformatf("rt_enc_k%0d_t%0d", k, m), lo_enc(out_data), k);
                    chk($sformatf("rt_err_k%0d_t%0d", k, m), {31'd0, out_err}, 32'd0);
                end else begin
                    chk($sformatf("rt_data_k%0d_t%0d", k, m), {23'd0, out_data}, 32'd0);
                    chk($sformatf("rt_err_k%0d_t%0d", k, m), {31'd0, out_err}, 32'd1);
                end
                drain($urandom_range(0, 3), out_data, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/leading_one_decoder.md
# leading_one_decoder

Iterative decoder that is the inverse of the team's leading-one index encoder. It accepts a 4-bit leading-one index over a valid/ready handshake and rebuilds a 9-bit value by shifting a single one upward, one bit per cycle. The output is either a one-hot word or a thermometer mask. It sits downstream of index-producing logic wherever a mask or one-hot value must be regenerated from a stored index. The same index encoding applies in both directions: 0 means no bit set, and k in 1..9 means bit k-1 is the most significant one.

## Interface
- `WIDTH`, default 9: output word width.
- `IDX_W`, default 4: index width; must satisfy 2^IDX_W > WIDTH.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: index request present.
- `in_ready` output, 1 bit: block can accept a request.
- `in_index` input, IDX_W bits: leading-one index.
- `in_therm` input, 1 bit: 1 selects thermometer output (bits k-1..0 set); 0 selects one-hot.
- `out_valid` output, 1 bit: result present.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_data` output, WIDTH bits: decoded word.
- `out_err` output, 1 bit: request had an out-of-range index.
- `busy` output, 1 bit: high whenever state is not IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - SHIFT: building the word.
  - DONE: `out_valid`=1, holding the result.
- Accept occurs in IDLE when `in_valid`=1 and `in_ready`=1. On accept, `in_index` is captured as k and `in_therm` as t.
  - k=0: `out_data` ← 0, `out_err` ← 0, go to DONE.
  - k>WIDTH (10..15): `out_data` ← 0, `out_err` ← 1, go to DONE.
  - k=1: `out_data` ← 1, go to DONE.
  - 2≤k≤WIDTH: `out_data` ← 1, count ← k-1, go to SHIFT.
- SHIFT, once per cycle:
  - If t=1: `out_data` ← {`out_data`[WIDTH-2:0], 1'b1}. If t=0: `out_data` ← `out_data` << 1.
  - count ← count-1.
  - On the edge where count==1 (the last shift), go to DONE.
- DONE: hold `out_data`, `out_err` and `out_valid` stable until `out_ready`=1, then go to IDLE.
- `in_ready` is low in SHIFT and DONE. There are no overlapping requests, and `in_*` is ignored outside IDLE.
- The count never underflows. The shift is WIDTH-bit with no carry out; bit WIDTH-1 is the highest bit ever set.
- Round trip: for every k in 0..9, encoding the produced `out_data` (either mode) with the leading-one encoder returns k.

## Timing
- Reset (`rst_n`=0, asynchronous) forces these values immediately:
  - state=IDLE, count=0
  - `out_data`=0, `out_err`=0, `out_valid`=0
  - `in_ready`=1 (combinational from state), `busy`=0
- Reset asserted mid-SHIFT or mid-DONE discards the request; no result is produced.
- Latency, with the accept cycle numbered 0:
  - `out_valid` first high in cycle k for 1≤k≤9.
  - `out_valid` first high in cycle 1 for k=0 and for error indices.
- DONE to IDLE takes one cycle after the `out_ready` handshake. The next accept is possible in the cycle after the output handshake, so throughput is one request per k+1 cycles minimum.
- `out_ready` asserted before DONE has no effect.
- `in_valid` with `in_ready`=0 is neither accepted nor lost by the block; the producer must hold it.

## Test plan
- Reset, then each k=0..9 with `in_therm`=0 and `out_ready`=1. Required:
  - `out_data`=0, 1, 2, 4, ... 9'h100 respectively.
  - `out_valid` first in cycle max(k,1).
  - `out_err`=0.
- Thermometer mode, k=1..9. Required `out_data`=9'h001, 9'h003, ... 9'h1FF; k=5 gives 9'h01F.
- Error indices k=10 and k=15. Required: `out_data`=0, `out_err`=1, `out_valid` in cycle 1.
- Backpressure: k=4, `out_ready` held 0 for 6 cycles. Required:
  - `out_data` stays 9'h008 and `out_valid` stays 1.
  - `in_ready` stays 0 despite `in_valid`=1 with new indices.
  - After `out_ready`=1, IDLE follows and the next request is accepted.
- Reset mid-operation: accept k=9, drop `rst_n` in cycle 4. Required: outputs 0 and `in_ready`=1 immediately; no `out_valid` after release.
- Round trip: all k=0..15 in both modes, with random `out_ready` stalls. Check that encoding `out_data` returns k for k≤9, and `out_err`=1 with data 0 for k>9.
